insn_boot_loader: RTL

//  Boot-time loader upstream of the rv32i core. Accepts a byte stream (valid/ready), assembles

---
 rtl/insn_boot_loader_if.sv | 39 +++
 rtl/insn_boot_loader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/insn_boot_loader_if.sv
// Byte-stream and instruction-memory write bundle for the boot loader.
// The master modport is the loader side; the slave modport is the stream source / memory side.
interface insn_boot_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_run;
  logic              done;
  logic              error;

  modport master (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output core_run,
    output done,
    output error
  );

  modport slave (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  core_run,
    input  done,
    input  error
  );
endinterface

// File: rtl/insn_boot_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte frame, writes little-endian
// words into instruction memory from word 0 and releases the core only on a good checksum.
module insn_boot_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  insn_boot_loader_if.master  bus
);

  localparam logic [2:0] S_LEN_LO = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  logic [2:0]        state_reg;
  logic [15:0]       len_reg;
  logic [1:0]        byte_cnt_reg;
  logic [ADDR_W:0]   word_cnt_reg;
  logic [7:0]        csum_reg;
  logic [7:0]        lane_reg [0:2];
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       mem_wdata_reg;
  logic              core_run_reg;
  logic              done_reg;
  logic              error_reg;

  logic              rx_ready;
  logic              accept;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   word_inc;

  assign rx_ready = (state_reg == S_LEN_LO) || (state_reg == S_LEN_HI) ||
                    (state_reg == S_DATA)   || (state_reg == S_CSUM);
  assign accept   = bus.rx_valid && rx_ready;
  assign len_full = {bus.rx_data, len_reg[7:0]};
  assign word_inc = word_cnt_reg + {{ADDR_W{1'b0}}, 1'b1};

  // Byte lanes 0..2 of the word under assembly; lane 3 is taken straight from rx_data
  // on the completing byte so the write strobe follows with no extra bubble.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          lane_reg[gi] <= 8'h00;
        end else if (accept && (state_reg == S_DATA) && (byte_cnt_reg == 2'(gi))) begin
          lane_reg[gi] <= bus.rx_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_LEN_LO;
      len_reg       <= 16'h0000;
      byte_cnt_reg  <= 2'd0;
      word_cnt_reg  <= '0;
      csum_reg      <= 8'h00;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= 32'h0000_0000;
      core_run_reg  <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      mem_we_reg <= 1'b0;
      if (accept) begin
        case (state_reg)
          S_LEN_LO: begin
            len_reg[7:0] <= bus.rx_data;
            state_reg    <= S_LEN_HI;
          end
          S_LEN_HI: begin
            len_reg[15:8] <= bus.rx_data;
            if (len_full > 16'(DEPTH)) begin
              state_reg <= S_ERROR;
              error_reg <= 1'b1;
            end else if (len_full == 16'h0000) begin
              state_reg <= S_CSUM;
            end else begin
              state_reg <= S_DATA;
            end
          end
          S_DATA: begin
            csum_reg     <= csum_reg ^ bus.rx_data;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              mem_we_reg    <= 1'b1;
              mem_addr_reg  <= word_cnt_reg[ADDR_W-1:0];
              mem_wdata_reg <= {bus.rx_data, lane_reg[2], lane_reg[1], lane_reg[0]};
              word_cnt_reg  <= word_inc;
              // Last word of the image: the checksum byte comes next.
              if (16'(word_inc) == len_reg) begin
                state_reg <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            if (bus.rx_data == csum_reg) begin
              state_reg    <= S_RUN;
              core_run_reg <= 1'b1;
              done_reg     <= 1'b1;
            end else begin
              state_reg <= S_ERROR;
              error_reg <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.rx_ready  = rx_ready;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.core_run  = core_run_reg;
  assign bus.done      = done_reg;
  assign bus.error     = error_reg;

endmodule
